// File: rtl/param_matrix_multiplier.sv
// Square signed matrix multiplier over an internal word memory holding A, B and C.
// One MAC per cycle; each C element is saturated to DATA_W on write-back, optionally accumulating.
module param_matrix_multiplier #(
  parameter int DATA_W = 32,
  parameter int N      = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] memory_data_in,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic              write_enable,
  input  logic              start,
  input  logic              accumulate,
  output logic [DATA_W-1:0] memory_data_out,
  output logic              result_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int MEM_D  = 3 * N * N;
  localparam int MEM_AW = $clog2(MEM_D);
  localparam int IDX_W  = $clog2(N);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(N) + 1;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  logic [DATA_W-1:0] mem_q [MEM_D];

  state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic mode_q, mode_d;
  logic busy_q, busy_d, ready_q, ready_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic host_ok_s, host_we_s, start_ok_s, c_we_s, sat_hi_s, sat_lo_s;
  logic [MEM_AW-1:0] host_idx_s, a_addr_s, b_addr_s, c_addr_s;
  logic signed [DATA_W-1:0] a_s, b_s, c_old_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [SUM_W-1:0] sum_s;
  logic [DATA_W-1:0] c_new_s;

  assign host_ok_s  = (memory_address < ADDR_W'(MEM_D));
  assign host_idx_s = MEM_AW'(memory_address);
  assign host_we_s  = write_enable & ~busy_q & host_ok_s;
  assign start_ok_s = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  assign a_addr_s = MEM_AW'(i_q) * MEM_AW'(N) + MEM_AW'(k_q);
  assign b_addr_s = MEM_AW'(N * N) + MEM_AW'(k_q) * MEM_AW'(N) + MEM_AW'(j_q);
  assign c_addr_s = MEM_AW'(2 * N * N) + MEM_AW'(i_q) * MEM_AW'(N) + MEM_AW'(j_q);

  assign a_s     = mem_q[a_addr_s];
  assign b_s     = mem_q[b_addr_s];
  assign c_old_s = mem_q[c_addr_s];
  assign prod_s  = a_s * b_s;

  // Write-back value: widened sum, optionally with old C, clamped to the signed element range.
  always_comb begin
    sum_s    = SUM_W'(acc_q) + (mode_q ? SUM_W'(c_old_s) : {SUM_W{1'b0}});
    sat_hi_s = (sum_s > SAT_MAX);
    sat_lo_s = (sum_s < SAT_MIN);
    if (sat_hi_s) begin
      c_new_s = SAT_MAX[DATA_W-1:0];
    end else if (sat_lo_s) begin
      c_new_s = SAT_MIN[DATA_W-1:0];
    end else begin
      c_new_s = sum_s[DATA_W-1:0];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Word memory: deliberately unreset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (host_we_s) begin
      mem_q[host_idx_s] <= memory_data_in;
    end else if (c_we_s) begin
      mem_q[c_addr_s] <= c_new_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok_s) state_d = S_MAC;
        else            state_d = state_q;
      end
      S_MAC: begin
        if (k_q == LAST_IDX) state_d = S_WRITE;
        else                 state_d = S_MAC;
      end
      S_WRITE: begin
        if ((i_q == LAST_IDX) && (j_q == LAST_IDX)) state_d = S_DONE;
        else                                        state_d = S_MAC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, accumulator and sticky overflow.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    acc_d  = acc_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    c_we_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok_s) begin
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
          acc_d  = '0;
          mode_d = accumulate;
          ovf_d  = 1'b0;
        end else begin
          mode_d = mode_q;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (k_q == LAST_IDX) k_d = '0;
        else                 k_d = k_q + 1'b1;
      end
      S_WRITE: begin
        c_we_s = 1'b1;
        acc_d  = '0;
        if (sat_hi_s || sat_lo_s) ovf_d = 1'b1;
        else                      ovf_d = ovf_q;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) i_d = '0;
          else                 i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: begin
        acc_d = '0;
      end
    endcase
  end

  // Output logic, registered alongside the state.
  always_comb begin
    busy_d  = (state_d == S_MAC) || (state_d == S_WRITE);
    ready_d = (state_d == S_DONE);
    if (host_ok_s) rdata_d = mem_q[host_idx_s];
    else           rdata_d = '0;
  end

  assign memory_data_out = rdata_q;
  assign result_ready    = ready_q;
  assign busy            = busy_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Directed bench for param_matrix_multiplier at N=2, DATA_W=16 (A 0-3, B 4-7, C 8-11).
module tb_param_matrix_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] memory_data_in = 16'd0;
  logic [11:0] memory_address = 12'd0;
  logic        write_enable = 1'b0;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [15:0] memory_data_out;
  logic        result_ready, busy, overflow;

  int tests_run = 0;
  int tests_failed = 0;

  param_matrix_multiplier #(.DATA_W(16), .N(2), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .memory_data_in(memory_data_in),
    .memory_address(memory_address), .write_enable(write_enable),
    .start(start), .accumulate(accumulate), .memory_data_out(memory_data_out),
    .result_ready(result_ready), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic write_word(input int addr, input logic [15:0] data);
    @(negedge clk);
    memory_address = 12'(addr);
    memory_data_in = data;
    write_enable   = 1'b1;
    @(negedge clk);
    write_enable   = 1'b0;
  endtask

  task automatic load_ab(input logic [15:0] a [4], input logic [15:0] b [4]);
    for (int n = 0; n < 4; n++) write_word(n, a[n]);
    for (int n = 0; n < 4; n++) write_word(4 + n, b[n]);
  endtask

  task automatic read_word(input int addr, output logic [15:0] v);
    @(negedge clk);
    memory_address = 12'(addr);
    @(posedge clk);
    #1 v = memory_data_out;
  endtask

  // Issues start and counts busy cycles at negedges; optional injection during busy and early abort.
  task automatic run_job(input logic mode, input int inject_at, input int abort_at, output int cycles);
    @(negedge clk);
    start = 1'b1;
    accumulate = mode;
    @(negedge clk);
    start = 1'b0;
    accumulate = ~mode;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (cycles == abort_at) break;
      if (cycles == inject_at) begin
        memory_address = 12'd0;
        memory_data_in = 16'd9;
        write_enable   = 1'b1;
        start          = 1'b1;
        accumulate     = 1'b0;
      end else begin
        write_enable = 1'b0;
        start        = 1'b0;
      end
      @(negedge clk);
    end
    write_enable = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int cycles, input logic [15:0] exp [4], input logic exp_ovf);
    logic [15:0] v;
    tests_run++;
    if (cycles !== 12) begin
      tests_failed++;
      $display("FAIL %s busy_cycles got %0d want 12", name, cycles);
    end
    tests_run++;
    if (result_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s ready/busy got %b/%b want 1/0", name, result_ready, busy);
    end
    tests_run++;
    if (overflow !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s overflow got %b want %b", name, overflow, exp_ovf);
    end
    for (int n = 0; n < 4; n++) begin
      read_word(8 + n, v);
      tests_run++;
      if (v !== exp[n]) begin
        tests_failed++;
        $display("FAIL %s C[%0d] got %0d want %0d", name, n, $signed(v), $signed(exp[n]));
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (busy !== 1'b0 || result_ready !== 1'b0 || overflow !== 1'b0 || memory_data_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state got busy=%b rdy=%b ovf=%b dout=%h want 0/0/0/0000",
               busy, result_ready, overflow, memory_data_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_identity();
    int cyc;
    load_ab('{16'd1, 16'd0, 16'd0, 16'd1}, '{16'd1, 16'd2, 16'd3, 16'd4});
    run_job(1'b0, 0, 0, cyc);
    check_run("identity", cyc, '{16'd1, 16'd2, 16'd3, 16'd4}, 1'b0);
  endtask

  task automatic test_accumulate();
    int cyc;
    run_job(1'b1, 0, 0, cyc);
    check_run("accumulate", cyc, '{16'd2, 16'd4, 16'd6, 16'd8}, 1'b0);
  endtask

  task automatic test_signed();
    int cyc;
    load_ab('{-16'sd1, 16'd2, 16'd3, -16'sd4}, '{16'd5, 16'd6, 16'd7, 16'd8});
    run_job(1'b0, 0, 0, cyc);
    check_run("signed", cyc, '{16'd9, 16'd10, -16'sd13, -16'sd14}, 1'b0);
  endtask

  task automatic test_near_limit();
    int cyc;
    load_ab('{16'd32767, 16'd32767, 16'd32767, 16'd32767},
            '{16'd32767, 16'd32767, 16'h8000, 16'h8000});
    run_job(1'b0, 0, 0, cyc);
    check_run("near_limit", cyc, '{-16'sd32767, -16'sd32767, -16'sd32767, -16'sd32767}, 1'b0);
  endtask

  task automatic test_saturate();
    int cyc;
    load_ab('{16'd32767, 16'd32767, 16'd32767, 16'd32767},
            '{16'd32767, 16'h8000, 16'd32767, 16'h8000});
    run_job(1'b0, 0, 0, cyc);
    check_run("saturate", cyc, '{16'd32767, 16'h8000, 16'd32767, 16'h8000}, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    run_job(1'b0, 0, 5, cyc);
    tests_run++;
    if (busy !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_run_pre busy/ovf got %b/%b want 1/1", busy, overflow);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || result_ready !== 1'b0 || overflow !== 1'b0 || memory_data_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset got busy=%b rdy=%b ovf=%b dout=%h want 0/0/0/0000",
               busy, result_ready, overflow, memory_data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    load_ab('{16'd1, 16'd0, 16'd0, 16'd1}, '{16'd5, 16'd6, 16'd7, 16'd8});
    run_job(1'b0, 0, 0, cyc);
    check_run("restart", cyc, '{16'd5, 16'd6, 16'd7, 16'd8}, 1'b0);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    logic [15:0] v;
    run_job(1'b1, 3, 0, cyc);
    check_run("busy_ignore", cyc, '{16'd10, 16'd12, 16'd14, 16'd16}, 1'b0);
    read_word(0, v);
    tests_run++;
    if (v !== 16'd1) begin
      tests_failed++;
      $display("FAIL busy_write A[0] got %0d want 1", v);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || result_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_second_run busy/rdy got %b/%b want 0/1", busy, result_ready);
    end
  endtask

  task automatic test_start_with_write();
    int cyc;
    @(negedge clk);
    memory_address = 12'd0;
    memory_data_in = 16'd2;
    write_enable   = 1'b1;
    run_job(1'b0, 0, 0, cyc);
    check_run("start_with_write", cyc, '{16'd10, 16'd12, 16'd7, 16'd8}, 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_accumulate();
    test_signed();
    test_near_limit();
    test_saturate();
    test_reset_mid_run();
    test_busy_ignore();
    test_start_with_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
